// File: rtl/axi_sram_ctrl.sv
// axi_sram_ctrl: AXI4 INCR-burst subordinate driving a single-port 1-cycle SRAM, one burst at a time.
module axi_sram_ctrl #(
  parameter logic [63:0] MEM_BASE = 64'h0,
  parameter logic [63:0] MEM_SIZE = 64'h10000,
  parameter int DATA_W = 64,
  localparam int BYTES = DATA_W / 8,
  localparam int LB = $clog2(BYTES),
  localparam int MEM_AW = $clog2(MEM_SIZE / BYTES)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [63:0]       aw_addr_i,
  input  logic [7:0]        aw_len_i,
  input  logic              aw_valid_i,
  output logic              aw_ready_o,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [BYTES-1:0]  w_strb_i,
  input  logic              w_last_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  output logic [1:0]        b_resp_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  input  logic [63:0]       ar_addr_i,
  input  logic [7:0]        ar_len_i,
  input  logic              ar_valid_i,
  output logic              ar_ready_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic [1:0]        r_resp_o,
  output logic              r_last_o,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BYTES-1:0]  mem_strb_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
  state_t state;
  logic prio_rd, err, rd_done, infl, infl_ok, infl_last, in_rng, issue, pop;
  logic [63:0] start, addr, off;
  logic [7:0] len, cnt;
  logic [1:0] wp, rp, occ;
  logic [DATA_W+2:0] fifo [3];
  assign addr = start + ({56'b0, cnt} << LB);
  assign off = addr - MEM_BASE;
  assign in_rng = off < MEM_SIZE;
  // occupancy plus the read in flight must leave room in the 3-entry FIFO
  assign issue = state == READ && !rd_done && ({1'b0, occ} + {2'b0, infl} < 3'd3);
  assign pop = r_valid_o && r_ready_i;
  assign ar_ready_o = !srst_i && state == IDLE && ar_valid_i && (prio_rd || !aw_valid_i);
  assign aw_ready_o = !srst_i && state == IDLE && aw_valid_i && (!prio_rd || !ar_valid_i);
  assign w_ready_o = state == WRITE;
  assign b_resp_o = {err, 1'b0};
  assign r_valid_o = occ != 2'd0;
  assign {r_data_o, r_resp_o, r_last_o} = fifo[rp];
  assign mem_req_o = in_rng && ((state == WRITE && w_valid_i) || issue);
  assign mem_we_o = state == WRITE;
  assign mem_addr_o = off[LB +: MEM_AW];
  assign mem_wdata_o = w_data_i;
  assign mem_strb_o = w_strb_i;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
      prio_rd <= 1'b1;
      cnt <= 8'd0;
      err <= 1'b0;
      b_valid_o <= 1'b0;
      rd_done <= 1'b0;
      infl <= 1'b0;
      occ <= 2'd0;
      wp <= 2'd0;
      rp <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_ready_o) begin
            state <= READ;
            start <= ar_addr_i & ~64'(BYTES - 1);
            len <= ar_len_i;
            cnt <= 8'd0;
            rd_done <= 1'b0;
            prio_rd <= 1'b0;
          end else if (aw_ready_o) begin
            state <= WRITE;
            start <= aw_addr_i & ~64'(BYTES - 1);
            len <= aw_len_i;
            cnt <= 8'd0;
            err <= 1'b0;
            prio_rd <= 1'b1;
          end
        end
        WRITE: begin
          if (w_valid_i) begin
            err <= err | !in_rng | (cnt == len && !w_last_i);
            if (cnt == len) begin
              state <= WRESP;
              b_valid_o <= 1'b1;
            end else cnt <= cnt + 8'd1;
          end
        end
        WRESP: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            state <= IDLE;
          end
        end
        READ: begin
          if (issue) begin
            rd_done <= cnt == len;
            cnt <= cnt + 8'd1;
          end
          if (rd_done && !infl && occ == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      infl <= issue;
      infl_ok <= in_rng;
      infl_last <= cnt == len;
      // out-of-range beats ride the same pipeline as real reads, carrying zero data and SLVERR
      if (infl) begin
        fifo[wp] <= {infl_ok ? mem_rdata_i : '0, infl_ok ? 2'b00 : 2'b10, infl_last};
        wp <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
      end
      if (pop) rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
      occ <= occ + {1'b0, infl} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_axi_sram_ctrl.sv
// tb_axi_sram_ctrl: directed scenario bench for axi_sram_ctrl with a behavioural 1-cycle SRAM.
module tb_axi_sram_ctrl;
  logic clk = 0, srst = 0;
  logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0, r_data, mem_wdata, mem_rdata;
  logic [7:0] aw_len = 0, ar_len = 0, w_strb = 0, mem_strb;
  logic aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready, b_valid, b_ready = 0;
  logic ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 0, mem_req, mem_we;
  logic [1:0] b_resp, r_resp;
  logic [12:0] mem_addr;
  logic [63:0] sram [0:8191];
  int n_tests = 0, n_fail = 0;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CD00;
  localparam logic [63:0] E0 = 64'hFEED_0000_0000_0000;

  axi_sram_ctrl dut (
    .clk_i(clk), .srst_i(srst),
    .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_we)
      for (int b = 0; b < 8; b++) if (mem_strb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
  end

  task automatic do_reset();
    @(negedge clk);
    srst = 1;
    @(negedge clk);
    srst = 0;
  endtask

  task automatic do_write(input logic [63:0] a, input int len, input logic [63:0] d0);
    aw_addr = a; aw_len = 8'(len); aw_valid = 1;
    #1;
    for (int t = 0; t < 30 && !aw_ready; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    aw_valid = 0;
    for (int i = 0; i <= len; i++) begin
      w_valid = 1; w_data = d0 + 64'(i); w_strb = 8'hFF; w_last = (i == len);
      @(negedge clk);
    end
    w_valid = 0; w_last = 0; b_ready = 1;
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    srst = 1;
    @(negedge clk);
    #1;
    n_tests++; if (ar_ready !== 0) begin n_fail++; $display("FAIL reset_ar_ready got %b want 0", ar_ready); end
    n_tests++; if (aw_ready !== 0) begin n_fail++; $display("FAIL reset_aw_ready got %b want 0", aw_ready); end
    srst = 0;
    @(negedge clk);
    #1;
    n_tests++; if (w_ready !== 0) begin n_fail++; $display("FAIL reset_w_ready got %b want 0", w_ready); end
    n_tests++; if (b_valid !== 0) begin n_fail++; $display("FAIL reset_b_valid got %b want 0", b_valid); end
    n_tests++; if (r_valid !== 0) begin n_fail++; $display("FAIL reset_r_valid got %b want 0", r_valid); end
    n_tests++; if (mem_req !== 0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_write();
    @(negedge clk);
    aw_addr = 64'h10; aw_len = 3; aw_valid = 1;
    #1;
    n_tests++; if (aw_ready !== 1) begin n_fail++; $display("FAIL wr_aw_ready got %b want 1", aw_ready); end
    @(negedge clk);
    aw_valid = 0;
    for (int i = 0; i < 4; i++) begin
      w_valid = 1; w_data = D0 + 64'(i); w_strb = 8'hFF; w_last = (i == 3);
      #1;
      n_tests++; if ({w_ready, mem_req, mem_we} !== 3'b111) begin n_fail++; $display("FAIL wr_beat%0d_strobes got %b want 111", i, {w_ready, mem_req, mem_we}); end
      n_tests++; if (mem_addr !== 13'(2 + i)) begin n_fail++; $display("FAIL wr_beat%0d_addr got %0d want %0d", i, mem_addr, 2 + i); end
      @(negedge clk);
    end
    w_valid = 0; w_last = 0;
    #1;
    n_tests++; if (b_valid !== 1) begin n_fail++; $display("FAIL wr_b_valid got %b want 1", b_valid); end
    n_tests++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL wr_b_resp got %b want 00", b_resp); end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
    #1;
    n_tests++; if (b_valid !== 0) begin n_fail++; $display("FAIL wr_b_drop got %b want 0", b_valid); end
  endtask

  task automatic test_read();
    @(negedge clk);
    ar_addr = 64'h10; ar_len = 3; ar_valid = 1; r_ready = 1;
    #1;
    n_tests++; if (ar_ready !== 1) begin n_fail++; $display("FAIL rd_ar_ready got %b want 1", ar_ready); end
    @(negedge clk);
    ar_valid = 0;
    #1;
    n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 13'd2}) begin n_fail++; $display("FAIL rd_issue got req=%b we=%b addr=%0d want 1 0 2", mem_req, mem_we, mem_addr); end
    n_tests++; if (r_valid !== 0) begin n_fail++; $display("FAIL rd_t1_r_valid got %b want 0", r_valid); end
    @(negedge clk);
    #1;
    n_tests++; if (r_valid !== 0) begin n_fail++; $display("FAIL rd_t2_r_valid got %b want 0", r_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_tests++; if ({r_valid, r_last, r_resp} !== {1'b1, i == 3, 2'b00}) begin n_fail++; $display("FAIL rd_beat%0d_ctl got v=%b l=%b r=%b want 1 %b 00", i, r_valid, r_last, r_resp, i == 3); end
      n_tests++; if (r_data !== D0 + 64'(i)) begin n_fail++; $display("FAIL rd_beat%0d_data got %h want %h", i, r_data, D0 + 64'(i)); end
    end
    @(negedge clk);
    #1;
    n_tests++; if (r_valid !== 0) begin n_fail++; $display("FAIL rd_end_r_valid got %b want 0", r_valid); end
    r_ready = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_stall();
    int k = 0, issued = 0, maxo = 0;
    logic prev_stall = 0;
    logic [63:0] prev_d = 0;
    do_write(64'h100, 7, E0);
    ar_addr = 64'h100; ar_len = 7; ar_valid = 1;
    @(negedge clk);
    ar_valid = 0;
    for (int c = 0; c < 60; c++) begin
      r_ready = (c % 3 == 0);
      #1;
      if (r_valid && prev_stall) begin
        n_tests++; if (r_data !== prev_d) begin n_fail++; $display("FAIL stall_stable got %h want %h", r_data, prev_d); end
      end
      if (mem_req && !mem_we) issued++;
      if (r_valid && r_ready) begin
        n_tests++; if ({r_data, r_last} !== {E0 + 64'(k), k == 7}) begin n_fail++; $display("FAIL stall_beat%0d got %h/%b want %h/%b", k, r_data, r_last, E0 + 64'(k), k == 7); end
        k++;
      end
      if (issued - k > maxo) maxo = issued - k;
      prev_stall = r_valid && !r_ready;
      prev_d = r_data;
      @(negedge clk);
    end
    r_ready = 0;
    n_tests++; if (k !== 8) begin n_fail++; $display("FAIL stall_beats got %0d want 8", k); end
    n_tests++; if (issued !== 8) begin n_fail++; $display("FAIL stall_issued got %0d want 8", issued); end
    n_tests++; if (maxo !== 3) begin n_fail++; $display("FAIL stall_max_outstanding got %0d want 3", maxo); end
  endtask

  task automatic test_write_oob();
    @(negedge clk);
    aw_addr = 64'h10000 - 64'h8; aw_len = 1; aw_valid = 1;
    #1;
    for (int t = 0; t < 30 && !aw_ready; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    aw_valid = 0;
    w_valid = 1; w_data = 64'h55; w_strb = 8'hFF; w_last = 0;
    #1;
    n_tests++; if ({mem_req, mem_addr} !== {1'b1, 13'd8191}) begin n_fail++; $display("FAIL oob_beat0 got req=%b addr=%0d want 1 8191", mem_req, mem_addr); end
    @(negedge clk);
    w_last = 1;
    #1;
    n_tests++; if ({w_ready, mem_req} !== 2'b10) begin n_fail++; $display("FAIL oob_beat1 got ready=%b req=%b want 1 0", w_ready, mem_req); end
    @(negedge clk);
    w_valid = 0; w_last = 0;
    #1;
    n_tests++; if ({b_valid, b_resp} !== 3'b110) begin n_fail++; $display("FAIL oob_bresp got v=%b r=%b want 1 10", b_valid, b_resp); end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic test_arb();
    logic got_r = 0;
    do_reset();
    aw_addr = 64'h20; aw_len = 0; aw_valid = 1;
    ar_addr = 64'h10; ar_len = 0; ar_valid = 1; r_ready = 1;
    #1;
    n_tests++; if ({ar_ready, aw_ready} !== 2'b10) begin n_fail++; $display("FAIL arb_first got ar=%b aw=%b want 1 0", ar_ready, aw_ready); end
    @(negedge clk);
    ar_valid = 0;
    #1;
    for (int t = 0; t < 20 && !aw_ready; t++) begin
      if (r_valid) begin
        got_r = 1;
        n_tests++; if (r_data !== D0) begin n_fail++; $display("FAIL arb_rdata got %h want %h", r_data, D0); end
      end
      @(negedge clk);
      #1;
    end
    n_tests++; if ({got_r, aw_ready} !== 2'b11) begin n_fail++; $display("FAIL arb_write_granted got r=%b aw=%b want 1 1", got_r, aw_ready); end
    @(negedge clk);
    aw_valid = 0; r_ready = 0;
    w_valid = 1; w_data = 64'h77; w_strb = 8'h0F; w_last = 1;
    #1;
    n_tests++; if ({mem_req, mem_we, mem_addr} !== {2'b11, 13'd4}) begin n_fail++; $display("FAIL arb_wbeat got req=%b we=%b addr=%0d want 1 1 4", mem_req, mem_we, mem_addr); end
    @(negedge clk);
    w_valid = 0; w_last = 0;
    #1;
    n_tests++; if ({b_valid, b_resp} !== 3'b100) begin n_fail++; $display("FAIL arb_bresp got v=%b r=%b want 1 00", b_valid, b_resp); end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    @(negedge clk);
    ar_addr = 64'h100; ar_len = 7; ar_valid = 1; r_ready = 1;
    @(negedge clk);
    ar_valid = 0;
    for (int t = 0; t < 20 && k < 2; t++) begin
      #1;
      if (r_valid && r_ready) k++;
      @(negedge clk);
    end
    n_tests++; if (k !== 2) begin n_fail++; $display("FAIL mid_reach_beat2 got %0d want 2", k); end
    srst = 1;
    @(negedge clk);
    srst = 0;
    #1;
    n_tests++; if ({r_valid, mem_req, ar_ready} !== 3'b000) begin n_fail++; $display("FAIL mid_after_reset got rv=%b req=%b ar=%b want 000", r_valid, mem_req, ar_ready); end
    ar_addr = 64'h108; ar_len = 0; ar_valid = 1;
    #1;
    n_tests++; if (ar_ready !== 1) begin n_fail++; $display("FAIL mid_fresh_ar got %b want 1", ar_ready); end
    @(negedge clk);
    ar_valid = 0;
    @(negedge clk);
    #1;
    n_tests++; if (r_valid !== 0) begin n_fail++; $display("FAIL mid_t2_r_valid got %b want 0", r_valid); end
    @(negedge clk);
    #1;
    n_tests++; if ({r_valid, r_last, r_resp, r_data} !== {2'b11, 2'b00, E0 + 64'd1}) begin n_fail++; $display("FAIL mid_fresh_beat got v=%b l=%b r=%b d=%h want 1 1 00 %h", r_valid, r_last, r_resp, r_data, E0 + 64'd1); end
    @(negedge clk);
    r_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_stall();
    test_write_oob();
    test_arb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_sram_ctrl.md
Name: axi_sram_ctrl

Overview:
- AXI4 subordinate backend for the subsystem TCDM. Consumes INCR bursts from the DMA's outbound AXI port and drives a single-port, 1-cycle-latency SRAM macro.
- Serves one burst at a time with read/write round-robin arbitration. Sustains 1 beat/cycle in both directions and fully honours R/B backpressure.

Parameters:
- MEM_BASE, 64'h0, byte base address of the SRAM window.
- MEM_SIZE, 64'h10000, window size in bytes (power of two).
- DATA_W, 64, data width in bits; BYTES=DATA_W/8; MEM_AW=$clog2(MEM_SIZE/BYTES).

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
aw_addr_i  in  64  write burst start byte address
aw_len_i  in  8  write beats minus one
aw_valid_i  in  1  AW valid
aw_ready_o  out  1  AW ready
w_data_i  in  DATA_W  write data
w_strb_i  in  BYTES  byte strobes
w_last_i  in  1  last write beat
w_valid_i  in  1  W valid
w_ready_o  out  1  W ready
b_resp_o  out  2  write response (00 OKAY, 10 SLVERR)
b_valid_o  out  1  B valid
b_ready_i  in  1  B ready
ar_addr_i  in  64  read burst start byte address
ar_len_i  in  8  read beats minus one
ar_valid_i  in  1  AR valid
ar_ready_o  out  1  AR ready
r_data_o  out  DATA_W  read data
r_resp_o  out  2  read response (00 OKAY, 10 SLVERR)
r_last_o  out  1  last read beat
r_valid_o  out  1  R valid
r_ready_i  in  1  R ready
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  MEM_AW  SRAM word index
mem_wdata_o  out  DATA_W  SRAM write data
mem_strb_o  out  BYTES  SRAM byte enables
mem_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read mem_req_o

Behaviour:
- Reset (srst_i=1 at an edge): all *_valid_o, *_ready_o and mem_req_o are 0. FSM goes to IDLE. Priority flag favours read. Beat counters and the R FIFO are cleared. A burst in progress is abandoned with no B/R response.
- FSM IDLE->WRITE->WRESP->IDLE and IDLE->READ->IDLE. In IDLE, aw_ready_o/ar_ready_o is asserted combinationally for the granted channel only. If both are valid, the channel not granted last wins. After a grant, the priority flips to the other channel.
- Beat address = start + beat*BYTES. The low log2(BYTES) bits of the start address are ignored. The sum wraps modulo 2^64.
- A beat is in range iff MEM_BASE <= addr < MEM_BASE+MEM_SIZE. In range: mem_addr_o = (addr-MEM_BASE)>>log2(BYTES). Out-of-range beats never assert mem_req_o.
- WRITE: w_ready_o=1. Each W handshake issues mem_req_o=mem_we_o=1 in the same cycle, with w_data/w_strb passed through.
- The beat counter (aw_len+1 beats) ends the burst, not w_last_i. w_last_i is ignored on non-final beats.
- b_resp_o=SLVERR if any beat was out of range or w_last_i=0 on the final beat; otherwise OKAY.
- WRESP: b_valid_o rises the cycle after the final W handshake and holds with stable b_resp_o until b_ready_i.
- READ: reads are issued back-to-back into a 3-entry R FIFO. A beat issues only when FIFO occupancy + in-flight < 3.
- Out-of-range read beats are pushed as data 0 with resp SLVERR, using the same timing as an SRAM read. r_last_o marks beat aw_len/ar_len.
- R FIFO: pushed at the edge ending the mem_rdata_i cycle; r_* outputs come from the FIFO head.
- Read latency: AR handshake in cycle T, first r_valid_o in T+3. With r_ready_i=1 the rate is 1 beat/cycle.
- READ exits to IDLE once all beats are issued and the FIFO has drained. r_valid_o/r_data_o stay stable while r_ready_i=0.

Test Plan:
- Write aw_addr=MEM_BASE+0x10, aw_len=3, 4 beats strb=0xFF -> mem_addr 2,3,4,5 with mem_we=1 on consecutive cycles; b_valid the cycle after beat 3, b_resp=00.
- Read ar_addr=MEM_BASE+0x10, ar_len=3, r_ready=1 -> first r_valid at T+3, 4 consecutive beats of the written data, r_last on beat 3, r_resp=00.
- Read ar_len=7 with r_ready toggling 1,0,0,1,... -> no beat lost or duplicated; FIFO never exceeds 3; r_data stable while stalled.
- Write aw_addr=MEM_BASE+MEM_SIZE-0x8, aw_len=1 -> beat 0 written at the last word, beat 1 suppressed (mem_req=0), b_resp=10.
- aw_valid and ar_valid both asserted in IDLE after reset -> read granted first; after it completes, the pending write is granted.
- srst_i pulsed mid read burst (beat 2 of 8) -> next cycle r_valid=0, mem_req=0, FSM IDLE; a fresh AR is accepted normally.
